// File: rtl/cud_job_issuer.sv
// cud_job_issuer: initiator side of the CUD start/done handshake.
// Buffers (v, x) Q5.11 operand jobs in a small FIFO, issues them to the CUD
// one at a time (vSig/XSig/start), waits for a rising done, captures the
// distance and returns it through a valid/ready result port.
// Optional feature macro: CUD_JOB_TIMEOUT_EN -- aborts a job whose done never
// rises within TIMEOUT cycles of entering WAIT, returning a zero result
// flagged by res_timeout and pulsing cud_rst.
module cud_job_issuer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_v,
  input  logic [15:0] in_x,
  output logic [15:0] vSig,
  output logic [15:0] XSig,
  output logic        start,
  output logic        cud_rst,
  input  logic        done,
  input  logic [15:0] distance,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_distance,
  output logic        res_timeout,
  output logic        busy
);

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Reject illegal parameterisations at elaboration
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cud_job_issuer: DEPTH must be a power of two and at least 2");
  end
  if (START_CYCLES < 1) begin : g_bad_start
    $error("cud_job_issuer: START_CYCLES must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cud_job_issuer: TIMEOUT must be at least 1");
  end

  // Job FIFO storage and pointers (extra MSB separates full from empty)
  logic [2*DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;

  // FSM and registered outputs
  logic [1:0]      r_state,     w_state_nxt;
  logic [SCW-1:0]  r_scnt,      w_scnt_nxt;
  logic            r_start,     w_start_nxt;
  logic [DW-1:0]   r_vsig,      w_vsig_nxt;
  logic [DW-1:0]   r_xsig,      w_xsig_nxt;
  logic            r_res_valid, w_res_valid_nxt;
  logic [DW-1:0]   r_res_dist,  w_res_dist_nxt;
  logic            r_cud_rst,   w_cud_rst_nxt;
  logic            r_done_q;

`ifdef CUD_JOB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]   r_tcnt,      w_tcnt_nxt;
  logic            r_res_to,    w_res_to_nxt;
`endif

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_done_rise;
  logic            w_slot_free;
  logic [2*DW-1:0] w_head;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push      = in_valid && !w_full;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_done_rise = done && !r_done_q;
  // The result slot frees up in the same cycle the consumer takes it
  assign w_slot_free = !r_res_valid || res_ready;

  // Next-state and next-output logic for the issue FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_scnt_nxt      = r_scnt;
    w_start_nxt     = r_start;
    w_vsig_nxt      = r_vsig;
    w_xsig_nxt      = r_xsig;
    w_res_valid_nxt = r_res_valid;
    w_res_dist_nxt  = r_res_dist;
    w_cud_rst_nxt   = 1'b0;
    w_pop           = 1'b0;
`ifdef CUD_JOB_TIMEOUT_EN
    w_tcnt_nxt      = r_tcnt;
    w_res_to_nxt    = r_res_to;
`endif

    if (r_res_valid && res_ready) begin
      w_res_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (!w_empty && w_slot_free) begin
          w_pop       = 1'b1;
          w_vsig_nxt  = w_head[2*DW-1:DW];
          w_xsig_nxt  = w_head[DW-1:0];
          w_start_nxt = 1'b1;
          w_scnt_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // done edges seen here belong to a previous job and are ignored
        if (r_scnt == SCW'(START_CYCLES - 1)) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_WAIT;
`ifdef CUD_JOB_TIMEOUT_EN
          w_tcnt_nxt  = '0;
`endif
        end else begin
          w_scnt_nxt = r_scnt + SCW'(1);
        end
      end
      S_WAIT: begin
        if (w_done_rise) begin
          w_res_dist_nxt  = distance;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
`ifdef CUD_JOB_TIMEOUT_EN
          w_res_to_nxt    = 1'b0;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_res_dist_nxt  = '0;
          w_res_valid_nxt = 1'b1;
          w_res_to_nxt    = 1'b1;
          w_cud_rst_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
`endif
        end
      end
      default: begin
        w_start_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards every queued or pending job
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_scnt      <= '0;
      r_start     <= 1'b0;
      r_vsig      <= '0;
      r_xsig      <= '0;
      r_res_valid <= 1'b0;
      r_res_dist  <= '0;
      r_cud_rst   <= 1'b1;
      r_done_q    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
`ifdef CUD_JOB_TIMEOUT_EN
      r_tcnt      <= '0;
      r_res_to    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_scnt      <= w_scnt_nxt;
      r_start     <= w_start_nxt;
      r_vsig      <= w_vsig_nxt;
      r_xsig      <= w_xsig_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_dist  <= w_res_dist_nxt;
      r_cud_rst   <= w_cud_rst_nxt;
      r_done_q    <= done;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
`ifdef CUD_JOB_TIMEOUT_EN
      r_tcnt      <= w_tcnt_nxt;
      r_res_to    <= w_res_to_nxt;
`endif
    end
  end

  // FIFO payload write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_v, in_x};
    end
  end

  assign in_ready     = !w_full;
  assign vSig         = r_vsig;
  assign XSig         = r_xsig;
  assign start        = r_start;
  assign cud_rst      = r_cud_rst;
  assign res_valid    = r_res_valid;
  assign res_distance = r_res_dist;
  assign busy         = (r_state != S_IDLE) || !w_empty;
`ifdef CUD_JOB_TIMEOUT_EN
  assign res_timeout  = r_res_to;
`else
  assign res_timeout  = 1'b0;
`endif

endmodule
